// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-serial memory port engine between ICache
// refill, the load/store buffer and the instruction prefetcher.
// Optional starvation guard for ICache behind MEM_ARB_STARVE_EN.
// Ports:
//   clk_in, rst_in (async, active-low), rdy_in (global enable), _clear
//   io_buffer_full            UART full; blocks LSB stores to IO_ADDR
//   _ic_*, _lsb_*, _pf_*      requester inputs, _*_ack response strobes
//   _rdata                    response data, valid with the ack
//   _req_*, _req_ready        request handshake to the port engine
//   _resp_valid, _resp_data   engine completion
module mem_arbiter #(
   parameter int          STARVE_LIMIT = 8,
   parameter logic [31:0] IO_ADDR      = 32'h30000
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   input  logic        _clear,
   input  logic        io_buffer_full,
   input  logic        _ic_req,
   input  logic [31:0] _ic_addr,
   input  logic        _lsb_req,
   input  logic        _lsb_wr,
   input  logic [1:0]  _lsb_size,
   input  logic [31:0] _lsb_addr,
   input  logic [31:0] _lsb_wdata,
   input  logic        _pf_req,
   input  logic [31:0] _pf_addr,
   output logic        _ic_ack,
   output logic        _lsb_ack,
   output logic        _pf_ack,
   output logic [31:0] _rdata,
   output logic        _req_valid,
   output logic        _req_wr,
   output logic [1:0]  _req_size,
   output logic [31:0] _req_addr,
   output logic [31:0] _req_wdata,
   input  logic        _req_ready,
   input  logic        _resp_valid,
   input  logic [31:0] _resp_data
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWN_IC  = 2'd0,
      OWN_LSB = 2'd1,
      OWN_PF  = 2'd2
   } owner_t;

   state_t      state, state_n;
   owner_t      owner, owner_n;
   logic        req_valid_n, req_wr_n;
   logic [1:0]  req_size_n;
   logic [31:0] req_addr_n, req_wdata_n, rdata_n;
   logic        ic_ack_n, lsb_ack_n, pf_ack_n;
   logic        can_gnt, lsb_ok, starve_hit;
   logic        g_ic, g_lsb, g_pf, cancel_ok;

   // The ack cycle is kept grant-free: the acked requester
   // still holds its req high during that cycle.
   assign can_gnt = (state == IDLE) && !_clear &&
                    !(_ic_ack || _lsb_ack || _pf_ack);

   assign lsb_ok = _lsb_req &&
                   !(_lsb_wr && io_buffer_full &&
                     (_lsb_addr == IO_ADDR));

   assign g_ic  = can_gnt && _ic_req && (!lsb_ok || starve_hit);
   assign g_lsb = can_gnt && lsb_ok && !g_ic;
   assign g_pf  = can_gnt && _pf_req && !lsb_ok && !_ic_req;

   // Stores have side effects and are never cancelled by a flush.
   assign cancel_ok = (owner != OWN_LSB) || !_req_wr;

`ifdef MEM_ARB_STARVE_EN
   localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

   logic [3:0] starve_cnt;

   assign starve_hit = (starve_cnt >= LIMIT);

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         starve_cnt <= '0;
      end else if (rdy_in) begin
         if (!_ic_req || g_ic)
            starve_cnt <= '0;
         else if (g_lsb && (starve_cnt != 4'hf))
            starve_cnt <= starve_cnt + 4'd1;
      end
   end
`else
   assign starve_hit = 1'b0;
`endif

   always_comb begin
      state_n     = state;
      owner_n     = owner;
      req_valid_n = _req_valid;
      req_wr_n    = _req_wr;
      req_size_n  = _req_size;
      req_addr_n  = _req_addr;
      req_wdata_n = _req_wdata;
      rdata_n     = _rdata;
      ic_ack_n    = 1'b0;
      lsb_ack_n   = 1'b0;
      pf_ack_n    = 1'b0;
      unique case (state)
         IDLE: begin
            unique case (1'b1)
               g_ic: begin
                  owner_n     = OWN_IC;
                  req_wr_n    = 1'b0;
                  req_size_n  = 2'd3;
                  req_addr_n  = _ic_addr;
                  req_wdata_n = '0;
               end
               g_lsb: begin
                  owner_n     = OWN_LSB;
                  req_wr_n    = _lsb_wr;
                  req_size_n  = _lsb_size;
                  req_addr_n  = _lsb_addr;
                  req_wdata_n = _lsb_wdata;
               end
               g_pf: begin
                  owner_n     = OWN_PF;
                  req_wr_n    = 1'b0;
                  req_size_n  = 2'd3;
                  req_addr_n  = _pf_addr;
                  req_wdata_n = '0;
               end
               default: ;
            endcase
            if (g_ic || g_lsb || g_pf) begin
               req_valid_n = 1'b1;
               state_n     = ISSUE;
            end
         end
         ISSUE: begin
            // A flush landing on the accept edge cannot recall the
            // request, so its response is drained instead.
            if (_req_ready) begin
               req_valid_n = 1'b0;
               state_n = (_clear && cancel_ok) ? DRAIN : BUSY;
            end else if (_clear && cancel_ok) begin
               req_valid_n = 1'b0;
               state_n     = IDLE;
            end
         end
         BUSY: begin
            if (_resp_valid) begin
               state_n = IDLE;
               if (!(_clear && cancel_ok)) begin
                  rdata_n = _resp_data;
                  case (owner)
                     OWN_IC:  ic_ack_n  = 1'b1;
                     OWN_LSB: lsb_ack_n = 1'b1;
                     default: pf_ack_n  = 1'b1;
                  endcase
               end
            end else if (_clear && cancel_ok) begin
               state_n = DRAIN;
            end
         end
         DRAIN: begin
            if (_resp_valid)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state      <= IDLE;
         owner      <= OWN_IC;
         _req_valid <= 1'b0;
         _req_wr    <= 1'b0;
         _req_size  <= '0;
         _req_addr  <= '0;
         _req_wdata <= '0;
         _rdata     <= '0;
         _ic_ack    <= 1'b0;
         _lsb_ack   <= 1'b0;
         _pf_ack    <= 1'b0;
      end else if (rdy_in) begin
         state      <= state_n;
         owner      <= owner_n;
         _req_valid <= req_valid_n;
         _req_wr    <= req_wr_n;
         _req_size  <= req_size_n;
         _req_addr  <= req_addr_n;
         _req_wdata <= req_wdata_n;
         _rdata     <= rdata_n;
         _ic_ack    <= ic_ack_n;
         _lsb_ack   <= lsb_ack_n;
         _pf_ack    <= pf_ack_n;
      end
   end

   a_limit: assert property (@(posedge clk_in) disable iff (!rst_in)
      (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 15));

   a_resp: assert property (@(posedge clk_in) disable iff (!rst_in)
      (rdy_in && _resp_valid) |-> (state == BUSY || state == DRAIN));

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a small
// port-engine model and per-requester expected-response queues.
module tb_mem_arbiter;

   localparam logic [31:0] IO_ADDR = 32'h30000;
   localparam logic [31:0] KEY     = 32'hC0DE_0000;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        _clear = 1'b0;
   logic        io_buffer_full = 1'b0;
   logic        _ic_req = 1'b0;
   logic [31:0] _ic_addr = '0;
   logic        _lsb_req = 1'b0;
   logic        _lsb_wr = 1'b0;
   logic [1:0]  _lsb_size = '0;
   logic [31:0] _lsb_addr = '0;
   logic [31:0] _lsb_wdata = '0;
   logic        _pf_req = 1'b0;
   logic [31:0] _pf_addr = '0;
   logic        _ic_ack, _lsb_ack, _pf_ack;
   logic [31:0] _rdata;
   logic        _req_valid, _req_wr;
   logic [1:0]  _req_size;
   logic [31:0] _req_addr, _req_wdata;
   logic        _req_ready = 1'b0;
   logic        _resp_valid = 1'b0;
   logic [31:0] _resp_data = '0;

   int total = 0;
   int bad   = 0;

   logic [31:0] ic_q[$];
   logic [31:0] lsb_q[$];
   logic [31:0] pf_q[$];
   logic [1:0]  gnt_log[$];
   int ic_left  = 0;
   int lsb_left = 0;
   int pf_left  = 0;
   bit eng_auto = 1'b1;
   int eng_lat  = 2;

   mem_arbiter #(.STARVE_LIMIT(2), .IO_ADDR(IO_ADDR)) dut (
      .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
      ._clear(_clear), .io_buffer_full(io_buffer_full),
      ._ic_req(_ic_req), ._ic_addr(_ic_addr),
      ._lsb_req(_lsb_req), ._lsb_wr(_lsb_wr),
      ._lsb_size(_lsb_size), ._lsb_addr(_lsb_addr),
      ._lsb_wdata(_lsb_wdata),
      ._pf_req(_pf_req), ._pf_addr(_pf_addr),
      ._ic_ack(_ic_ack), ._lsb_ack(_lsb_ack), ._pf_ack(_pf_ack),
      ._rdata(_rdata),
      ._req_valid(_req_valid), ._req_wr(_req_wr),
      ._req_size(_req_size), ._req_addr(_req_addr),
      ._req_wdata(_req_wdata), ._req_ready(_req_ready),
      ._resp_valid(_resp_valid), ._resp_data(_resp_data)
   );

   always #5 clk_in = ~clk_in;

   // 0 = IC, 1 = LSB, 2 = PF, recovered from the address map
   function automatic logic [1:0] own_of(logic [31:0] a);
      if (a == IO_ADDR) return 2'd1;
      case (a[15:12])
         4'h1:    return 2'd0;
         4'h2:    return 2'd1;
         default: return 2'd2;
      endcase
   endfunction

   task automatic engine();
      bit pend = 1'b0;
      int cnt = 0;
      logic [31:0] a = '0;
      forever begin
         @(negedge clk_in);
         if (!rst_in) begin
            pend = 1'b0;
            _req_ready = 1'b0;
            _resp_valid = 1'b0;
         end else if (eng_auto) begin
            _resp_valid = 1'b0;
            if (_req_ready) begin
               _req_ready = 1'b0;
               pend = 1'b1;
               cnt = eng_lat;
               a = _req_addr;
               gnt_log.push_back(own_of(_req_addr));
            end else if (pend) begin
               if (cnt == 0) begin
                  _resp_valid = 1'b1;
                  _resp_data = a ^ KEY;
                  pend = 1'b0;
               end else begin
                  cnt--;
               end
            end else if (_req_valid) begin
               _req_ready = 1'b1;
            end
         end
      end
   endtask

   task automatic monitor();
      logic [31:0] e;
      forever begin
         @(negedge clk_in);
         if (rst_in && _ic_ack) begin
            total++;
            if (ic_q.size() == 0) begin
               bad++;
               $display("FAIL ic_ack_unexpected rdata=%h", _rdata);
            end else begin
               e = ic_q.pop_front();
               if (_rdata !== e) begin
                  bad++;
                  $display("FAIL ic_rdata got=%h exp=%h", _rdata, e);
               end
            end
            if (ic_left > 0) ic_left--;
            if (ic_left == 0) _ic_req = 1'b0;
            else ic_q.push_back(_ic_addr ^ KEY);
         end
         if (rst_in && _lsb_ack) begin
            total++;
            if (lsb_q.size() == 0) begin
               bad++;
               $display("FAIL lsb_ack_unexpected rdata=%h", _rdata);
            end else begin
               e = lsb_q.pop_front();
               if (_rdata !== e) begin
                  bad++;
                  $display("FAIL lsb_rdata got=%h exp=%h", _rdata, e);
               end
            end
            if (lsb_left > 0) lsb_left--;
            if (lsb_left == 0) _lsb_req = 1'b0;
            else lsb_q.push_back(_lsb_addr ^ KEY);
         end
         if (rst_in && _pf_ack) begin
            total++;
            if (pf_q.size() == 0) begin
               bad++;
               $display("FAIL pf_ack_unexpected rdata=%h", _rdata);
            end else begin
               e = pf_q.pop_front();
               if (_rdata !== e) begin
                  bad++;
                  $display("FAIL pf_rdata got=%h exp=%h", _rdata, e);
               end
            end
            if (pf_left > 0) pf_left--;
            if (pf_left == 0) _pf_req = 1'b0;
            else pf_q.push_back(_pf_addr ^ KEY);
         end
      end
   endtask

   task automatic start_ic(logic [31:0] a, int n);
      _ic_addr = a;
      ic_left = n;
      ic_q.push_back(a ^ KEY);
      _ic_req = 1'b1;
   endtask

   task automatic start_lsb(logic [31:0] a, logic wr,
                            logic [1:0] sz, logic [31:0] wd, int n);
      _lsb_addr = a;
      _lsb_wr = wr;
      _lsb_size = sz;
      _lsb_wdata = wd;
      lsb_left = n;
      lsb_q.push_back(a ^ KEY);
      _lsb_req = 1'b1;
   endtask

   task automatic start_pf(logic [31:0] a, int n);
      _pf_addr = a;
      pf_left = n;
      pf_q.push_back(a ^ KEY);
      _pf_req = 1'b1;
   endtask

   task automatic wait_quiet(int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (!_ic_req && !_lsb_req && !_pf_req && !_req_valid) begin
            ok = 1'b1;
            repeat (2) @(negedge clk_in);
            return;
         end
      end
   endtask

   task automatic wait_grant(int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk_in);
         if (gnt_log.size() != 0) begin
            ok = 1'b1;
            return;
         end
      end
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({_req_valid, _req_wr, _req_size, _req_addr, _req_wdata,
           _ic_ack, _lsb_ack, _pf_ack, _rdata} !== '0) begin
         bad++;
         $display("FAIL reset_outputs valid=%b addr=%h rdata=%h",
                  _req_valid, _req_addr, _rdata);
      end
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
   endtask

   task automatic test_lone_ic();
      eng_auto = 1'b0;
      @(negedge clk_in);
      _ic_addr = 32'h1000;
      ic_left = 1;
      ic_q.push_back(32'h0050_0093);
      _ic_req = 1'b1;
      @(posedge clk_in); #1;
      total++;
      if (_req_valid !== 1'b1 || _req_addr !== 32'h1000) begin
         bad++;
         $display("FAIL lone_issue valid=%b addr=%h exp=1/00001000",
                  _req_valid, _req_addr);
      end
      total++;
      if (_req_size !== 2'd3 || _req_wr !== 1'b0) begin
         bad++;
         $display("FAIL lone_fields size=%0d wr=%b exp=3/0",
                  _req_size, _req_wr);
      end
      @(posedge clk_in); #1;
      total++;
      if (_req_valid !== 1'b1) begin
         bad++;
         $display("FAIL lone_hold valid=%b exp=1", _req_valid);
      end
      @(negedge clk_in);
      _req_ready = 1'b1;
      @(posedge clk_in); #1;
      total++;
      if (_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL lone_accept valid=%b exp=0", _req_valid);
      end
      @(negedge clk_in);
      _req_ready = 1'b0;
      repeat (2) @(negedge clk_in);
      _resp_data = 32'h0050_0093;
      _resp_valid = 1'b1;
      @(posedge clk_in); #1;
      total++;
      if (_ic_ack !== 1'b1 || _rdata !== 32'h0050_0093) begin
         bad++;
         $display("FAIL lone_ack ack=%b rdata=%h exp=1/00500093",
                  _ic_ack, _rdata);
      end
      @(negedge clk_in);
      _resp_valid = 1'b0;
      _resp_data = '0;
      @(posedge clk_in); #1;
      total++;
      if (_ic_ack !== 1'b0) begin
         bad++;
         $display("FAIL lone_ack_pulse ack=%b exp=0", _ic_ack);
      end
      eng_auto = 1'b1;
      repeat (2) @(negedge clk_in);
   endtask

   task automatic test_priority();
      bit seen = 1'b0;
      bit ok;
      gnt_log.delete();
      @(negedge clk_in);
      start_ic(32'h1100, 1);
      start_lsb(32'h2200, 1'b0, 2'd1, '0, 1);
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk_in);
         if (_lsb_ack) seen = 1'b1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL prio_lsb_ack timeout got=0 exp=1");
      end
      @(posedge clk_in); #1;
      total++;
      if (_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL prio_idle_gap valid=%b exp=0", _req_valid);
      end
      @(posedge clk_in); #1;
      total++;
      if (_req_valid !== 1'b1 || _req_addr !== 32'h1100) begin
         bad++;
         $display("FAIL prio_ic_next valid=%b addr=%h exp=1/00001100",
                  _req_valid, _req_addr);
      end
      wait_quiet(100, ok);
      total++;
      if (!ok || gnt_log.size() != 2) begin
         bad++;
         $display("FAIL prio_done ok=%b grants=%0d exp=1/2",
                  ok, gnt_log.size());
      end else if (gnt_log[0] !== 2'd1 || gnt_log[1] !== 2'd0) begin
         bad++;
         $display("FAIL prio_order got=%0d,%0d exp=1,0",
                  gnt_log[0], gnt_log[1]);
      end
   endtask

   task automatic test_io_gate();
      bit ok = 1'b0;
      gnt_log.delete();
      @(negedge clk_in);
      io_buffer_full = 1'b1;
      start_lsb(IO_ADDR, 1'b1, 2'd0, 32'h41, 1);
      start_ic(32'h1300, 1);
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk_in);
         if (!_ic_req) ok = 1'b1;
      end
      repeat (6) @(negedge clk_in);
      total++;
      if (!ok || gnt_log.size() != 1 || _req_valid !== 1'b0) begin
         bad++;
         $display("FAIL io_blocked ok=%b grants=%0d valid=%b exp=1/1/0",
                  ok, gnt_log.size(), _req_valid);
      end else if (gnt_log[0] !== 2'd0) begin
         bad++;
         $display("FAIL io_first got=%0d exp=0", gnt_log[0]);
      end
      io_buffer_full = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk_in);
         if (_req_valid) ok = 1'b1;
      end
      total++;
      if (!ok || _req_wr !== 1'b1 || _req_addr !== IO_ADDR ||
          _req_wdata !== 32'h41 || _req_size !== 2'd0) begin
         bad++;
         $display("FAIL io_store ok=%b wr=%b addr=%h wd=%h exp=1/1/%h/41",
                  ok, _req_wr, _req_addr, _req_wdata, IO_ADDR);
      end
      wait_quiet(100, ok);
      total++;
      if (!ok || gnt_log.size() != 2) begin
         bad++;
         $display("FAIL io_done ok=%b grants=%0d exp=1/2",
                  ok, gnt_log.size());
      end
   endtask

   task automatic test_clear_idle();
      bit ok;
      @(negedge clk_in);
      start_ic(32'h1400, 1);
      _clear = 1'b1;
      @(posedge clk_in); #1;
      total++;
      if (_req_valid !== 1'b0) begin
         bad++;
         $display("FAIL clr_idle_nogrant valid=%b exp=0", _req_valid);
      end
      @(negedge clk_in);
      _clear = 1'b0;
      @(posedge clk_in); #1;
      total++;
      if (_req_valid !== 1'b1 || _req_addr !== 32'h1400) begin
         bad++;
         $display("FAIL clr_idle_grant valid=%b addr=%h exp=1/00001400",
                  _req_valid, _req_addr);
      end
      wait_quiet(100, ok);
      total++;
      if (!ok) begin
         bad++;
         $display("FAIL clr_idle_done got=0 exp=1");
      end
   endtask

   task automatic test_clear_pf();
      bit ok;
      bit acked = 1'b0;
      bit back = 1'b0;
      gnt_log.delete();
      eng_lat = 6;
      @(negedge clk_in);
      start_pf(32'h4500, 1);
      wait_grant(30, ok);
      _clear = 1'b1;
      _pf_req = 1'b0;
      pf_left = 0;
      pf_q.delete();
      @(posedge clk_in); #1;
      total++;
      if (!ok || dut.state !== 2'd3) begin
         bad++;
         $display("FAIL clr_pf_drain ok=%b state=%0d exp=1/3",
                  ok, dut.state);
      end
      @(negedge clk_in);
      _clear = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk_in);
         if (_pf_ack) acked = 1'b1;
         if (dut.state === 2'd0) back = 1'b1;
      end
      total++;
      if (acked || !back) begin
         bad++;
         $display("FAIL clr_pf_swallow ack=%b idle=%b exp=0/1",
                  acked, back);
      end
      eng_lat = 2;
      start_ic(32'h1600, 1);
      wait_quiet(100, ok);
      total++;
      if (!ok || ic_q.size() != 0) begin
         bad++;
         $display("FAIL clr_pf_after ok=%b pend=%0d exp=1/0",
                  ok, ic_q.size());
      end
   endtask

   task automatic test_clear_store();
      bit ok;
      gnt_log.delete();
      eng_lat = 5;
      @(negedge clk_in);
      start_lsb(32'h2700, 1'b1, 2'd3, 32'hDEAD_BEEF, 1);
      wait_grant(30, ok);
      _clear = 1'b1;
      @(posedge clk_in); #1;
      total++;
      if (!ok || dut.state !== 2'd2) begin
         bad++;
         $display("FAIL clr_st_busy ok=%b state=%0d exp=1/2",
                  ok, dut.state);
      end
      @(negedge clk_in);
      _clear = 1'b0;
      wait_quiet(100, ok);
      total++;
      if (!ok || lsb_q.size() != 0) begin
         bad++;
         $display("FAIL clr_st_ack ok=%b pend=%0d exp=1/0",
                  ok, lsb_q.size());
      end
      eng_lat = 2;
   endtask

   task automatic test_starve();
      bit ok;
      logic [1:0] exp_g [6];
`ifdef MEM_ARB_STARVE_EN
      exp_g = '{2'd1, 2'd1, 2'd0, 2'd1, 2'd1, 2'd0};
`else
      exp_g = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd0, 2'd0};
`endif
      gnt_log.delete();
      @(negedge clk_in);
      start_lsb(32'h2800, 1'b0, 2'd3, '0, 4);
      start_ic(32'h1800, 2);
      wait_quiet(400, ok);
      total++;
      if (!ok || gnt_log.size() != 6) begin
         bad++;
         $display("FAIL starve_done ok=%b grants=%0d exp=1/6",
                  ok, gnt_log.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (gnt_log[i] !== exp_g[i]) begin
               bad++;
               $display("FAIL starve_grant%0d got=%0d exp=%0d",
                        i, gnt_log[i], exp_g[i]);
            end
         end
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      gnt_log.delete();
      eng_lat = 8;
      @(negedge clk_in);
      start_ic(32'h1900, 1);
      wait_grant(30, ok);
      @(negedge clk_in);
      #2 rst_in = 1'b0;
      #1;
      total++;
      if (!ok || {_req_valid, _req_wr, _req_size, _req_addr,
                  _req_wdata, _ic_ack, _lsb_ack, _pf_ack,
                  _rdata} !== '0) begin
         bad++;
         $display("FAIL arst_outputs ok=%b addr=%h rdata=%h exp=1/0/0",
                  ok, _req_addr, _rdata);
      end
      total++;
      if (dut.state !== 2'd0) begin
         bad++;
         $display("FAIL arst_state got=%0d exp=0", dut.state);
      end
      _ic_req = 1'b0;
      ic_left = 0;
      ic_q.delete();
      eng_lat = 2;
      repeat (2) @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      start_ic(32'h1A00, 1);
      wait_quiet(100, ok);
      total++;
      if (!ok || ic_q.size() != 0) begin
         bad++;
         $display("FAIL arst_after ok=%b pend=%0d exp=1/0",
                  ok, ic_q.size());
      end
   endtask

   initial begin
      fork
         engine();
         monitor();
      join_none
      test_reset();
      test_lone_ic();
      test_priority();
      test_io_gate();
      test_clear_idle();
      test_clear_pf();
      test_clear_store();
      test_starve();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
